// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: operand LIFO and op sequencer that drives an external combinational alu
module rpn_stack_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_type,
    input  logic [DATA_W-1:0]          cmd_data,
    input  logic [2:0]                 cmd_op,
    output logic [DATA_W-1:0]          alu_ain,
    output logic [DATA_W-1:0]          alu_bin,
    output logic [2:0]                 alu_op,
    input  logic [DATA_W-1:0]          alu_out,
    output logic [DATA_W-1:0]          top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       res_valid,
    output logic                       err,
    output logic [1:0]                 err_code
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC} state_t;
    state_t state, state_n;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     i0, i1, i2;
    logic [CW-1:0]     need;
    logic [1:0]        chk;
    logic              acc, ok, unary;

    assign i0        = AW'(depth);
    assign i1        = AW'(depth - CW'(1));
    assign i2        = AW'(depth - CW'(2));
    assign top       = (depth != '0) ? mem[i1] : '0;
    assign cmd_ready = state == IDLE;
    assign acc       = cmd_valid && cmd_ready;
    assign ok        = acc && chk == 2'b00;
    assign unary     = alu_op == 3'b011;
    assign need      = (cmd_op == 3'b011) ? CW'(1) : CW'(2);

    // Rejection priority for ops: illegal opcode, then underflow, then divide by zero
    always_comb begin
        chk = 2'b00;
        case (cmd_type)
            2'b00:   chk = (depth == CW'(DEPTH)) ? 2'b01 : 2'b00;
            2'b01:   chk = (cmd_op == 3'b111) ? 2'b11 :
                           (depth < need) ? 2'b10 :
                           (cmd_op == 3'b110 && top == '0) ? 2'b11 : 2'b00;
            2'b10:   chk = (depth == '0) ? 2'b10 : 2'b00;
            default: chk = 2'b00;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (ok && cmd_type == 2'b01) ? LOAD : IDLE;
            LOAD:    state_n = EXEC;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth     <= '0;
            alu_ain   <= '0;
            alu_bin   <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            res_valid <= 1'b0;
            err       <= 1'b0;
            if (acc && chk != 2'b00) begin
                err      <= 1'b1;
                err_code <= chk;
            end
            if (ok) begin
                case (cmd_type)
                    2'b00:   depth  <= depth + CW'(1);
                    2'b01:   alu_op <= cmd_op;
                    2'b10:   depth  <= depth - CW'(1);
                    default: depth  <= '0;
                endcase
            end
            if (state == LOAD) begin
                alu_ain <= unary ? mem[i1] : mem[i2];
                alu_bin <= unary ? '0 : mem[i1];
            end
            if (state == EXEC) begin
                depth     <= unary ? depth : depth - CW'(1);
                res_valid <= 1'b1;
            end
        end
    end

    // Storage is not reset; only depth defines which entries are meaningful
    always_ff @(posedge clk) begin
        if (ok && cmd_type == 2'b00) mem[i0] <= cmd_data;
        else if (state == EXEC)      mem[unary ? i1 : i2] <= alu_out;
    end
endmodule
